// File: rtl/m24_write_arb_if.sv
// Requester handshakes, writer-buffer strobe bus and occupancy status for m24_write_arb.
interface m24_write_arb_if;
  logic       REQ0_IN;
  logic [6:0] ADDR0_IN;
  logic [7:0] DATA0_IN;
  logic       ACK0_OUT;
  logic       REQ1_IN;
  logic [6:0] ADDR1_IN;
  logic [7:0] DATA1_IN;
  logic       ACK1_OUT;
  logic       ROM_WE_OUT;
  logic [6:0] ROM_ADDR_OUT;
  logic [7:0] ROM_DATA_OUT;
  logic [6:0] PENDING_OUT;
  logic       FULL_OUT;
  logic       BUSY_OUT;

  // Arbiter side.
  modport slave (
    input  REQ0_IN, ADDR0_IN, DATA0_IN,
    input  REQ1_IN, ADDR1_IN, DATA1_IN,
    output ACK0_OUT, ACK1_OUT,
    output ROM_WE_OUT, ROM_ADDR_OUT, ROM_DATA_OUT,
    output PENDING_OUT, FULL_OUT, BUSY_OUT
  );

  // Requester / observer side.
  modport master (
    output REQ0_IN, ADDR0_IN, DATA0_IN,
    output REQ1_IN, ADDR1_IN, DATA1_IN,
    input  ACK0_OUT, ACK1_OUT,
    input  ROM_WE_OUT, ROM_ADDR_OUT, ROM_DATA_OUT,
    input  PENDING_OUT, FULL_OUT, BUSY_OUT
  );
endinterface

// File: rtl/m24_write_arb.sv
// Two-requester round-robin write arbiter in front of the EEPROM byte writer.
// Tracks how many bytes the downstream buffer still holds by retiring one byte
// per write slot of 5 us ticks; the first retire after going busy waits two
// slots so the estimate is never early.
module m24_write_arb #(
  parameter int SLOT_PULSES = 4096,
  parameter int DEPTH       = 127
) (
  input  logic           SYSCLK_IN,
  input  logic           RESET_IN,
  input  logic           PULSE5uS_IN,
  m24_write_arb_if.slave bus
);

  localparam logic [6:0]  DEPTH_C  = 7'(DEPTH);
  localparam logic [12:0] FIRST_M1 = 13'(2 * SLOT_PULSES - 1);
  localparam logic [12:0] SLOT_M1  = 13'(SLOT_PULSES - 1);

  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        rom_we_q, rom_we_d;
  logic [6:0]  rom_addr_q, rom_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic [6:0]  pending_q, pending_d;
  logic        full_q, full_d;
  logic        busy_q, busy_d;
  logic        last_q, last_d;    // 1: requester 1 was granted most recently
  logic        first_q, first_d;  // 1: current retire window is the doubled first one
  logic [12:0] timer_q, timer_d;

  logic elig0, elig1, grant0, grant1, grant, retire;

  // Round-robin grant; a requester whose ACK is currently high sits out one cycle.
  always_comb begin
    elig0  = bus.REQ0_IN & ~ack0_q;
    elig1  = bus.REQ1_IN & ~ack1_q;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (pending_q != DEPTH_C) begin
      grant0 = elig0 & (~elig1 | last_q);
      grant1 = elig1 & (~elig0 | ~last_q);
    end
    grant  = grant0 | grant1;
    last_d = grant1 ? 1'b1 : (grant0 ? 1'b0 : last_q);
  end

  // Registered strobe and payload; payload holds when nothing is granted.
  always_comb begin
    ack0_d     = grant0;
    ack1_d     = grant1;
    rom_we_d   = grant;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    if (grant1) begin
      rom_addr_d = bus.ADDR1_IN;
      rom_data_d = bus.DATA1_IN;
    end else if (grant0) begin
      rom_addr_d = bus.ADDR0_IN;
      rom_data_d = bus.DATA0_IN;
    end
  end

  // Slot timer: idles at zero with the doubled window armed while nothing is outstanding.
  always_comb begin
    timer_d = timer_q;
    first_d = first_q;
    retire  = 1'b0;
    if (pending_q == 7'd0) begin
      timer_d = 13'd0;
      first_d = 1'b1;
    end else if (PULSE5uS_IN) begin
      if (timer_q == (first_q ? FIRST_M1 : SLOT_M1)) begin
        retire  = 1'b1;
        timer_d = 13'd0;
        first_d = 1'b0;
      end else begin
        timer_d = timer_q + 13'd1;
      end
    end
  end

  // Outstanding-byte count; a grant and a retire in the same cycle cancel.
  always_comb begin
    pending_d = pending_q;
    if (grant && !retire) begin
      pending_d = pending_q + 7'd1;
    end else if (retire && !grant) begin
      pending_d = pending_q - 7'd1;
    end
    full_d = (pending_d == DEPTH_C);
    busy_d = (pending_d != 7'd0);
  end

  // State and output registers.
  always_ff @(posedge SYSCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rom_we_q   <= 1'b0;
      rom_addr_q <= 7'd0;
      rom_data_q <= 8'd0;
      pending_q  <= 7'd0;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
      last_q     <= 1'b1;
      first_q    <= 1'b1;
      timer_q    <= 13'd0;
    end else begin
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rom_we_q   <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      pending_q  <= pending_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
      first_q    <= first_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.ACK0_OUT     = ack0_q;
  assign bus.ACK1_OUT     = ack1_q;
  assign bus.ROM_WE_OUT   = rom_we_q;
  assign bus.ROM_ADDR_OUT = rom_addr_q;
  assign bus.ROM_DATA_OUT = rom_data_q;
  assign bus.PENDING_OUT  = pending_q;
  assign bus.FULL_OUT     = full_q;
  assign bus.BUSY_OUT     = busy_q;

endmodule

// File: tb/tb_m24_write_arb.sv
// Bench for m24_write_arb with SLOT_PULSES=8, DEPTH=4, one tick every 4 cycles.
module tb_m24_write_arb;
  localparam int SLOT  = 8;
  localparam int DEPTH = 4;

  logic SYSCLK_IN = 1'b0;
  logic RESET_IN  = 1'b1;
  logic PULSE5uS_IN;

  m24_write_arb_if bus ();

  m24_write_arb #(.SLOT_PULSES(SLOT), .DEPTH(DEPTH)) dut (
    .SYSCLK_IN   (SYSCLK_IN),
    .RESET_IN    (RESET_IN),
    .PULSE5uS_IN (PULSE5uS_IN),
    .bus         (bus)
  );

  always #5 SYSCLK_IN = ~SYSCLK_IN;

  logic       drv_req0 = 0, drv_req1 = 0, drv_pulse = 0;
  logic [6:0] drv_addr0 = 0, drv_addr1 = 0;
  logic [7:0] drv_data0 = 0, drv_data1 = 0;

  assign bus.REQ0_IN  = drv_req0;
  assign bus.ADDR0_IN = drv_addr0;
  assign bus.DATA0_IN = drv_data0;
  assign bus.REQ1_IN  = drv_req1;
  assign bus.ADDR1_IN = drv_addr1;
  assign bus.DATA1_IN = drv_data1;
  assign PULSE5uS_IN  = drv_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ticks;

  // Reference model: outstanding bytes plus ticks left before the next retire.
  int         m_pending, m_remaining;
  bit         m_last;
  logic       m_ack0, m_ack1, m_we;
  logic [6:0] m_addr;
  logic [7:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_remaining = 2 * SLOT; m_last = 1;
    m_ack0 = 0; m_ack1 = 0; m_we = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_step();
    bit e0, e1, g0, g1, ret;
    ret = drv_pulse && (m_pending != 0) && (m_remaining == 1);
    e0 = drv_req0 && !m_ack0;
    e1 = drv_req1 && !m_ack1;
    g0 = 0; g1 = 0;
    if (m_pending < DEPTH) begin
      if (e0 && e1) begin
        if (m_last) g0 = 1; else g1 = 1;
      end else begin
        g0 = e0; g1 = e1;
      end
    end
    if (m_pending == 0) m_remaining = 2 * SLOT;
    else if (drv_pulse) m_remaining = (m_remaining == 1) ? SLOT : m_remaining - 1;
    m_pending = m_pending + int'(g0 | g1) - int'(ret);
    m_ack0 = g0; m_ack1 = g1; m_we = g0 | g1;
    if (g0) begin m_addr = drv_addr0; m_data = drv_data0; m_last = 0; end
    if (g1) begin m_addr = drv_addr1; m_data = drv_data1; m_last = 1; end
  endtask

  task automatic compare_all();
    chk("ack0",    bus.ACK0_OUT,     m_ack0);
    chk("ack1",    bus.ACK1_OUT,     m_ack1);
    chk("rom_we",  bus.ROM_WE_OUT,   m_we);
    chk("addr",    bus.ROM_ADDR_OUT, m_addr);
    chk("data",    bus.ROM_DATA_OUT, m_data);
    chk("pending", bus.PENDING_OUT,  m_pending);
    chk("full",    bus.FULL_OUT,     m_pending == DEPTH);
    chk("busy",    bus.BUSY_OUT,     m_pending != 0);
  endtask

  task automatic cycle();
    @(posedge SYSCLK_IN);
    if (!RESET_IN) model_step();
    cyc++;
    @(negedge SYSCLK_IN);
    compare_all();
    drv_pulse = (cyc % 4 == 3);
  endtask

  task automatic do_reset();
    @(negedge SYSCLK_IN);
    RESET_IN = 1;
    drv_req0 = 0; drv_req1 = 0;
    model_reset();
    repeat (2) @(posedge SYSCLK_IN);
    @(negedge SYSCLK_IN);
    RESET_IN = 0;
    compare_all();
    drv_pulse = (cyc % 4 == 3);
  endtask

  task automatic drive_random();
    if (drv_req0) begin
      if (m_ack0) begin
        if ($urandom_range(1, 0) == 1) drv_req0 = 0;
        else begin drv_addr0 = 7'($urandom); drv_data0 = 8'($urandom); end
      end
    end else if ($urandom_range(3, 0) == 0) begin
      drv_req0 = 1; drv_addr0 = 7'($urandom); drv_data0 = 8'($urandom);
    end
    if (drv_req1) begin
      if (m_ack1) begin
        if ($urandom_range(1, 0) == 1) drv_req1 = 0;
        else begin drv_addr1 = 7'($urandom); drv_data1 = 8'($urandom); end
      end
    end else if ($urandom_range(3, 0) == 0) begin
      drv_req1 = 1; drv_addr1 = 7'($urandom); drv_data1 = 8'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset();

    // Single write, late REQ drop, then first retire after 16 ticks.
    drv_req0 = 1; drv_addr0 = 7'h12; drv_data0 = 8'hA5;
    cycle();
    chk("single_ack0", bus.ACK0_OUT, 1);
    chk("single_we", bus.ROM_WE_OUT, 1);
    chk("single_addr", bus.ROM_ADDR_OUT, 7'h12);
    chk("single_data", bus.ROM_DATA_OUT, 8'hA5);
    chk("single_pending", bus.PENDING_OUT, 1);
    ticks = 0;
    if (drv_pulse) ticks++;
    cycle();
    chk("no_double_ack0", bus.ACK0_OUT, 0);
    drv_req0 = 0;
    for (int i = 0; i < 100 && bus.PENDING_OUT != 0; i++) begin
      if (drv_pulse) ticks++;
      cycle();
    end
    chk("first_retire_tick", ticks, 16);
    chk("idle_busy", bus.BUSY_OUT, 0);

    // Both held: alternate grants until full, then retire-at-full with REQ1 held.
    do_reset();
    drv_req0 = 1; drv_addr0 = 7'h01; drv_data0 = 8'h10;
    drv_req1 = 1; drv_addr1 = 7'h02; drv_data1 = 8'h20;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("alt_ack0", bus.ACK0_OUT, (k % 2) == 0);
      chk("alt_ack1", bus.ACK1_OUT, (k % 2) == 1);
    end
    cycle();
    chk("full_flag", bus.FULL_OUT, 1);
    chk("full_no_ack", bus.ACK0_OUT | bus.ACK1_OUT, 0);
    drv_req0 = 0;
    repeat (150) cycle();
    drv_req1 = 0;

    // Reset while ACK1 is high at PENDING=3.
    do_reset();
    drv_req1 = 1; drv_addr1 = 7'h33; drv_data1 = 8'h44;
    cycle();
    drv_req0 = 1; drv_addr0 = 7'h55; drv_data0 = 8'h66;
    cycle();
    cycle();
    chk("pre_rst_ack1", bus.ACK1_OUT, 1);
    chk("pre_rst_pending", bus.PENDING_OUT, 3);
    RESET_IN = 1;
    model_reset();
    #1;
    chk("rst_ack1", bus.ACK1_OUT, 0);
    chk("rst_we", bus.ROM_WE_OUT, 0);
    chk("rst_pending", bus.PENDING_OUT, 0);
    @(posedge SYSCLK_IN);
    @(negedge SYSCLK_IN);
    RESET_IN = 0;
    cycle();
    chk("post_rst_tie", bus.ACK0_OUT, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
